e1_xfer_arbiter: RTL
====================

Name: e1_xfer_arbiter

Overview:
Round-robin scheduler that shares the single E1 DDR<->BRAM transfer engine among NUM_REQ requesters, e.g. FM-A load, FM-B load and result store in the FM_ADD flow. It accepts one transfer descriptor at a time: direction, DDR base address and BRAM base address. It pulses the engine's module_en with the descriptor and waits for module_done. It then returns a per-requester done pulse. Sits between the FM_ADD top-level sequencer and the ddr_to_bram engine.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
APP_ADDR_WIDTH, 32, DDR address width, matches engine
BRAM_ADDR_WIDTH, 6, BRAM address width, matches engine
TIMEOUT_CYCLES, 4096, watchdog limit (used only with XFER_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
init_calib_complete  in  1  DDR calibration done; no grants while low
req  in  NUM_REQ  per-requester request level, held until req_ack
req_rd_wr  in  NUM_REQ  per-requester direction (0: DDR->BRAM, 1: BRAM->DDR)
req_ddr_addr  in  NUM_REQ*APP_ADDR_WIDTH  packed DDR base addresses, requester i at slice i
req_bram_addr  in  NUM_REQ*BRAM_ADDR_WIDTH  packed BRAM base addresses
req_ack  out  NUM_REQ  one-hot 1-cycle pulse: descriptor accepted
req_done  out  NUM_REQ  one-hot 1-cycle pulse: transfer complete
busy  out  1  high from ISSUE through GAP
err  out  1  sticky abort/timeout flag; cleared on next grant
module_en  out  1  engine start pulse
rd_wr  out  1  engine direction
ddr_begin_addr  out  APP_ADDR_WIDTH  engine DDR base
bram_begin_addr  out  BRAM_ADDR_WIDTH  engine BRAM base
module_done  in  1  engine completion pulse

Behaviour:
- Reset (async, rst=1): state IDLE, rr_ptr=0. All outputs are 0: req_ack, req_done, busy, err, module_en, rd_wr, ddr_begin_addr, bram_begin_addr.
- FSM states:
  - IDLE -> ISSUE when init_calib_complete=1 and |req.
  - ISSUE lasts 1 cycle -> WAIT.
  - WAIT -> GAP on module_done.
  - GAP lasts 1 cycle -> IDLE.
- Arbitration in IDLE: the winner is the first requester with req set, searching from rr_ptr upward with wrap at NUM_REQ-1 -> 0. In that same cycle the controller registers the winner's index, rd_wr and both addresses, and pulses req_ack[winner]. rr_ptr becomes winner+1 (mod NUM_REQ).
- ISSUE: module_en=1 for exactly one cycle. rd_wr, ddr_begin_addr and bram_begin_addr are already stable in that cycle and stay held until the next grant.
- Latency:
  - req rise to req_ack: 1 cycle.
  - req_ack to module_en: 1 cycle.
  - module_done to req_done[winner]: 1 cycle (registered, asserted on entry to GAP).
- The GAP cycle guarantees that module_en never occurs in the cycle after module_done.
- Requesters must drop req, or present a new descriptor, after req_ack. A req still high in the next IDLE is treated as a new request.
- module_done seen outside WAIT is ignored; no req_done is produced.
- module_done coinciding with a new req: the new req is not arbitrated until IDLE.
- init_calib_complete falling in ISSUE or WAIT: go to IDLE and set err=1. module_en is forced to 0 that cycle. No req_done is produced for the aborted transfer.
- With all requesters asserting continuously, grants rotate 0,1,2,0,...; no requester waits more than NUM_REQ-1 other transfers.

Optional Feature:
XFER_TIMEOUT_EN:
- Defined: a counter clears on entering WAIT and increments each WAIT cycle. If it reaches TIMEOUT_CYCLES-1 without module_done, go to IDLE, set err=1, and suppress req_done.
- Undefined: no counter; WAIT waits indefinitely.

Decomposition:
- Package e1_xfer_pkg: FSM state enum (IDLE, ISSUE, WAIT, GAP) and the RD_WR direction constants.
- One sub-module, e1_rr_arbiter (combinational round-robin pick from req and rr_ptr, returning grant one-hot and index), instantiated once.

Test Plan:
- Single request: req=3'b010, rd_wr=1, ddr=0x1000, bram=5. Expect req_ack[1] in the cycle after req. Expect module_en 1 cycle later with ddr_begin_addr=0x1000, bram_begin_addr=5, rd_wr=1. Drive module_done 20 cycles later; expect req_done[1] 1 cycle after.
- Fairness: req=3'b111 held, module_done returned 10 cycles after each module_en. Expect grant order 0,1,2,0,1,2 and no module_en in the cycle after any module_done.
- Calibration gating: init_calib_complete=0 with req=3'b001. Expect no req_ack. Raise calibration; expect req_ack[0] 1 cycle later.
- Abort: drop init_calib_complete while in WAIT. Expect FSM back in IDLE, err=1, no req_done. The next grant clears err.
- Stray done: pulse module_done while IDLE. Expect no req_done and no state change.
- Timeout (XFER_TIMEOUT_EN, TIMEOUT_CYCLES=16): no module_done. Expect err=1 and return to IDLE after 16 WAIT cycles; req_done stays 0.

Source files
------------

// File: rtl/e1_xfer_pkg.sv
// Shared types for the E1 transfer arbiter: controller state encoding and the
// engine direction values carried on rd_wr.
package e1_xfer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } xfer_state_t;

  localparam logic RD_WR_DDR_TO_BRAM = 1'b0;
  localparam logic RD_WR_BRAM_TO_DDR = 1'b1;

endpackage

// File: rtl/e1_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr,
// wrapping from NUM_REQ-1 back to 0.
module e1_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               valid
);

  int cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(rr_ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!valid && req[IDX_W'(cand)]) begin
        valid                 = 1'b1;
        grant_idx             = IDX_W'(cand);
        grant[IDX_W'(cand)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/e1_xfer_arbiter.sv
// Shares the single E1 DDR<->BRAM transfer engine among NUM_REQ requesters.
// Optional engine watchdog enabled by defining XFER_TIMEOUT_EN.
module e1_xfer_arbiter
  import e1_xfer_pkg::*;
#(
  parameter int NUM_REQ         = 3,
  parameter int APP_ADDR_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH = 6,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 init_calib_complete,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ-1:0]                   req_rd_wr,
  input  logic [NUM_REQ*APP_ADDR_WIDTH-1:0]    req_ddr_addr,
  input  logic [NUM_REQ*BRAM_ADDR_WIDTH-1:0]   req_bram_addr,
  output logic [NUM_REQ-1:0]                   req_ack,
  output logic [NUM_REQ-1:0]                   req_done,
  output logic                                 busy,
  output logic                                 err,
  output logic                                 module_en,
  output logic                                 rd_wr,
  output logic [APP_ADDR_WIDTH-1:0]            ddr_begin_addr,
  output logic [BRAM_ADDR_WIDTH-1:0]           bram_begin_addr,
  input  logic                                 module_done
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("e1_xfer_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
  end

  xfer_state_t        state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, pick_idx, ptr_nxt;
  logic [NUM_REQ-1:0] pick_grant, win_grant;
  logic               pick_valid;
  logic               grant_fire, abort, done_fire, timeout_hit;

  e1_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .valid     (pick_valid)
  );

  assign grant_fire = (state == ST_IDLE) && init_calib_complete && pick_valid;
  assign abort      = ((state == ST_ISSUE) || (state == ST_WAIT)) && !init_calib_complete;
  assign done_fire  = (state == ST_WAIT) && init_calib_complete && module_done;
  assign ptr_nxt    = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
  assign busy       = (state != ST_IDLE);

`ifdef XFER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  logic [TO_W-1:0] wait_cnt;

  // Counts cycles spent in WAIT; restarted while ISSUE hands over to WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + TO_W'(1);
    end
  end

  assign timeout_hit = (state == ST_WAIT) && init_calib_complete && !module_done &&
                       (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Calibration loss wins over a coincident module_done in WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant_fire) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = abort ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (abort)            state_nxt = ST_IDLE;
        else if (done_fire)   state_nxt = ST_GAP;
        else if (timeout_hit) state_nxt = ST_IDLE;
      end
      ST_GAP:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Registered handshake pulses; the descriptor is latched at grant time and
  // held on the engine inputs until the following grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr          <= '0;
      win_grant       <= '0;
      req_ack         <= '0;
      req_done        <= '0;
      err             <= 1'b0;
      module_en       <= 1'b0;
      rd_wr           <= 1'b0;
      ddr_begin_addr  <= '0;
      bram_begin_addr <= '0;
    end else begin
      req_ack   <= '0;
      req_done  <= '0;
      module_en <= 1'b0;
      if (grant_fire) begin
        req_ack         <= pick_grant;
        win_grant       <= pick_grant;
        rr_ptr          <= ptr_nxt;
        err             <= 1'b0;
        rd_wr           <= req_rd_wr[pick_idx];
        ddr_begin_addr  <= req_ddr_addr[pick_idx*APP_ADDR_WIDTH +: APP_ADDR_WIDTH];
        bram_begin_addr <= req_bram_addr[pick_idx*BRAM_ADDR_WIDTH +: BRAM_ADDR_WIDTH];
      end
      if ((state == ST_ISSUE) && init_calib_complete) module_en <= 1'b1;
      if (done_fire) req_done <= win_grant;
      if (abort || timeout_hit) err <= 1'b1;
    end
  end

endmodule
